// File: rtl/ps2_pkg.sv
// ps2_pkg - shared definitions for the PS/2 keyboard receive path.
//
// Contents:
//   PS2_EXT_PREFIX / PS2_BRK_PREFIX  prefix bytes resolved by the assembler
//   PS2_SYNC_STAGES, PS2_FILTER_LEN,
//   PS2_TIMEOUT_CYCLES               default parameter values
//   frame_state_t                    2-bit frame receiver state encoding
//   odd_parity_ok()                  odd-parity check over data + parity bit
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX     = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX     = 8'hF0;
    localparam int         PS2_SYNC_STAGES    = 2;
    localparam int         PS2_FILTER_LEN     = 8;
    localparam int         PS2_TIMEOUT_CYCLES = 100_000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // A frame is good when the data bits plus the parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_scan_assembler_if.sv
// ps2_scan_assembler_if - output bundle of the PS/2 scan-code assembler.
//
// Signals:
//   scan_code  [15:0] {8'hE0 or 8'h00, code byte}, held until the next finished
//   break_code        1 = key release, held with scan_code
//   finished          one-cycle strobe, scan_code/break_code valid on this cycle
//   raw_byte   [7:0]  last correctly framed byte (prefix bytes included)
//   byte_valid        one-cycle strobe per correctly framed byte
//   frame_err         one-cycle strobe on stop, parity or timeout error
// Modports:
//   master  driven by ps2_scan_assembler
//   slave   consumed by the downstream input decoder
interface ps2_scan_assembler_if;

    logic [15:0] scan_code;
    logic        break_code;
    logic        finished;
    logic [7:0]  raw_byte;
    logic        byte_valid;
    logic        frame_err;

    modport master (
        output scan_code, break_code, finished, raw_byte, byte_valid, frame_err
    );

    modport slave (
        input scan_code, break_code, finished, raw_byte, byte_valid, frame_err
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx - PS/2 frame receiver: synchronisers, clock glitch filter,
// 11-bit frame FSM, parity check and inter-edge timeout.
//
// Configuration macro: PS2_PARITY_CHECK_EN
//   defined   - a parity mismatch discards the byte and raises frame_err
//   undefined - the parity bit is sampled but never rejects a byte
//
// Ports:
//   clk, rst_b       system clock, asynchronous active-low reset
//   ps2_clk/ps2_data raw asynchronous PS/2 pins (receive only)
//   raw_byte         last good byte, updates the cycle after the stop sample
//   byte_valid       one-cycle strobe alongside raw_byte update
//   frame_err        one-cycle strobe the cycle after a stop/parity/timeout error
//   byte_next        received data byte, meaningful while byte_good is high
//   byte_good        combinational strobe on the stop sample of a good frame
//   err_now          combinational strobe on the cycle an error is detected
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = PS2_SYNC_STAGES,
    parameter int FILTER_LEN     = PS2_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] raw_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] byte_next,
    output logic       byte_good,
    output logic       err_now
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   filt_clk;
    logic [FW-1:0]          filt_cnt;
    logic                   sample;
    logic [TW-1:0]          to_cnt;
    logic                   timeout_hit;
    frame_state_t           state;
    frame_state_t           state_next;
    logic [7:0]             shift;
    logic [2:0]             bit_cnt;
    logic                   parity_q;
    logic                   parity_raw_ok;
    logic                   parity_ok;
    logic                   stop_sample;

    // Synchronisers reset to the idle-high level of the bus
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s != filt_clk) begin
            if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // Sample point: the cycle on which the filtered clock is about to fall
    assign sample = filt_clk && !clk_s && (filt_cnt == FW'(FILTER_LEN - 1));

    // A sample point on the same cycle always beats the timeout
    assign timeout_hit = (state != ST_IDLE) && !sample && (to_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            to_cnt <= '0;
        end else if (state == ST_IDLE || sample || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = ST_IDLE;
        end else if (sample) begin
            unique case (state)
                ST_IDLE:   if (!data_s) state_next = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_next = ST_PARITY;
                ST_PARITY: state_next = ST_STOP;
                ST_STOP:   state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    assign parity_raw_ok = odd_parity_ok(shift, parity_q);

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = parity_raw_ok;
`else
    // Parity is still captured but never rejects a byte in this build
    assign parity_ok = parity_raw_ok | 1'b1;
`endif

    always_comb begin
        stop_sample = 1'b0;
        byte_good   = 1'b0;
        err_now     = 1'b0;
        if (state == ST_STOP && sample) begin
            stop_sample = 1'b1;
        end
        byte_good = stop_sample && data_s && parity_ok;
        err_now   = timeout_hit || (stop_sample && !(data_s && parity_ok));
    end

    // Data bits arrive LSB first, so they shift in from the top
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            shift    <= '0;
            bit_cnt  <= '0;
            parity_q <= 1'b0;
        end else if (sample) begin
            unique case (state)
                ST_IDLE:   bit_cnt  <= '0;
                ST_DATA: begin
                    shift   <= {data_s, shift[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                ST_PARITY: parity_q <= data_s;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            raw_byte   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= byte_good;
            frame_err  <= err_now;
            if (byte_good) begin
                raw_byte <= shift;
            end
        end
    end

    assign byte_next = shift;

endmodule

// File: rtl/ps2_scan_assembler.sv
// ps2_scan_assembler - turns raw PS/2 pins into prefix-resolved scan codes.
//
// Configuration macro: PS2_PARITY_CHECK_EN (see ps2_frame_rx)
//
// Ports:
//   clk, rst_b        system clock, asynchronous active-low reset
//   ps2_clk/ps2_data  raw asynchronous PS/2 pins (never driven)
//   bus (master)      scan_code, break_code, finished, raw_byte,
//                     byte_valid, frame_err
module ps2_scan_assembler
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = PS2_SYNC_STAGES,
    parameter int FILTER_LEN     = PS2_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    ps2_scan_assembler_if.master bus
);

    logic [7:0]  raw_byte;
    logic        byte_valid;
    logic        frame_err;
    logic [7:0]  byte_next;
    logic        byte_good;
    logic        err_now;
    logic        ext_q;
    logic        brk_q;
    logic [15:0] scan_q;
    logic        break_q;
    logic        finished_q;
    logic        is_ext;
    logic        is_brk;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk        (clk),
        .rst_b      (rst_b),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .raw_byte   (raw_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .byte_next  (byte_next),
        .byte_good  (byte_good),
        .err_now    (err_now)
    );

    assign is_ext = (byte_next == PS2_EXT_PREFIX);
    assign is_brk = (byte_next == PS2_BRK_PREFIX);

    // Registered off the stop-sample strobe so finished lines up with byte_valid
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            scan_q     <= '0;
            break_q    <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            finished_q <= byte_good && !is_ext && !is_brk;
            if (err_now) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_good) begin
                if (is_ext) begin
                    ext_q <= 1'b1;
                end else if (is_brk) begin
                    brk_q <= 1'b1;
                end else begin
                    scan_q  <= {(ext_q ? PS2_EXT_PREFIX : 8'h00), byte_next};
                    break_q <= brk_q;
                    ext_q   <= 1'b0;
                    brk_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.scan_code  = scan_q;
    assign bus.break_code = break_q;
    assign bus.finished   = finished_q;
    assign bus.raw_byte   = raw_byte;
    assign bus.byte_valid = byte_valid;
    assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_ps2_scan_assembler.sv
// tb_ps2_scan_assembler - directed self-checking bench for ps2_scan_assembler.
// PS/2 clock is scaled down (HALF cycles per phase) and the timeout shortened
// so every scenario stays short.
module tb_ps2_scan_assembler;

    localparam int HALF    = 20;
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst_b;
    logic ps2_clk;
    logic ps2_data;

    ps2_scan_assembler_if bus ();

    ps2_scan_assembler #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus.master)
    );

    always #10 clk = ~clk;

    int          num_checks = 0;
    int          num_fail   = 0;
    int          cycle      = 0;
    int          bv_count   = 0;
    int          fin_count  = 0;
    int          err_count  = 0;
    int          misalign   = 0;
    int          err_cycle  = 0;
    int          last_fall  = 0;
    logic [15:0] last_scan  = '0;
    logic        last_brk   = 1'b0;
    logic [7:0]  last_raw   = '0;

    // Strobe monitor, sampled on the falling edge away from DUT updates
    always @(negedge clk) begin
        cycle++;
        if (bus.byte_valid) begin
            bv_count++;
            last_raw = bus.raw_byte;
        end
        if (bus.finished) begin
            fin_count++;
            last_scan = bus.scan_code;
            last_brk  = bus.break_code;
            if (!bus.byte_valid) misalign++;
        end
        if (bus.frame_err) begin
            err_count++;
            err_cycle = cycle;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first n_edges bits of a frame; optional 3-cycle glitch in bit glitch_bit
    task automatic applyStimulus(input logic [7:0] code, input bit bad_parity,
                                 input int n_edges, input int glitch_bit);
        logic [10:0] bits;
        bits = {1'b1, (~^code) ^ bad_parity, code, 1'b0};
        for (int i = 0; i < n_edges; i++) begin
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                waitCycles(8);
                ps2_clk = 1'b0;
                waitCycles(3);
                ps2_clk = 1'b1;
                waitCycles(HALF - 11);
            end else begin
                waitCycles(HALF);
            end
            ps2_clk   = 1'b0;
            last_fall = cycle;
            waitCycles(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        waitCycles(2 * HALF);
    endtask

    task automatic sendAndCheck(input string tag, input logic [7:0] code, input bit bad_parity,
                                input int glitch_bit, input int exp_bv, input int exp_fin,
                                input int exp_err, input logic [15:0] exp_scan, input logic exp_brk);
        int bv0, fin0, err0;
        bv0  = bv_count;
        fin0 = fin_count;
        err0 = err_count;
        applyStimulus(code, bad_parity, 11, glitch_bit);
        checkOutput({tag, "_byte_valid"}, bv_count - bv0, exp_bv);
        checkOutput({tag, "_finished"},   fin_count - fin0, exp_fin);
        checkOutput({tag, "_frame_err"},  err_count - err0, exp_err);
        if (exp_bv != 0) checkOutput({tag, "_raw_byte"}, last_raw, code);
        if (exp_fin != 0) begin
            checkOutput({tag, "_scan_code"},  last_scan, exp_scan);
            checkOutput({tag, "_break_code"}, last_brk, exp_brk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bv0, fin0, err0, waited, delay;
        rst_b    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        waitCycles(5);
        checkOutput("reset_scan_code", bus.scan_code, 16'h0000);
        checkOutput("reset_raw_byte",  bus.raw_byte, 8'h00);
        checkOutput("reset_finished",  bus.finished, 1'b0);
        rst_b = 1'b1;
        waitCycles(10);

        // Plain make code
        sendAndCheck("make_1D", 8'h1D, 0, -1, 1, 1, 0, 16'h001D, 1'b0);

        // Extended release sequence, then a plain code with no leftover prefixes
        sendAndCheck("pre_E0",  8'hE0, 0, -1, 1, 0, 0, 16'h0000, 1'b0);
        sendAndCheck("pre_F0",  8'hF0, 0, -1, 1, 0, 0, 16'h0000, 1'b0);
        sendAndCheck("ext_brk_75", 8'h75, 0, -1, 1, 1, 0, 16'hE075, 1'b1);
        sendAndCheck("after_1D", 8'h1D, 0, -1, 1, 1, 0, 16'h001D, 1'b0);
        checkOutput("held_scan_code", bus.scan_code, 16'h001D);

        // Repeated prefixes are idempotent
        sendAndCheck("rep_E0a", 8'hE0, 0, -1, 1, 0, 0, 16'h0000, 1'b0);
        sendAndCheck("rep_E0b", 8'hE0, 0, -1, 1, 0, 0, 16'h0000, 1'b0);
        sendAndCheck("rep_E06B", 8'h6B, 0, -1, 1, 1, 0, 16'hE06B, 1'b0);
        sendAndCheck("rep_F0a", 8'hF0, 0, -1, 1, 0, 0, 16'h0000, 1'b0);
        sendAndCheck("rep_F0b", 8'hF0, 0, -1, 1, 0, 0, 16'h0000, 1'b0);
        sendAndCheck("rep_F06B", 8'h6B, 0, -1, 1, 1, 0, 16'h006B, 1'b1);

`ifdef PS2_PARITY_CHECK_EN
        sendAndCheck("par_E0",  8'hE0, 0, -1, 1, 0, 0, 16'h0000, 1'b0);
        sendAndCheck("par_bad", 8'h27, 1, -1, 0, 0, 1, 16'h0000, 1'b0);
        sendAndCheck("par_27",  8'h27, 0, -1, 1, 1, 0, 16'h0027, 1'b0);
`else
        sendAndCheck("par_ignored", 8'h27, 1, -1, 1, 1, 0, 16'h0027, 1'b0);
`endif

        // Stop bit low is always a framing error; an E0 before it must be dropped
        sendAndCheck("stop_E0", 8'hE0, 0, -1, 1, 0, 0, 16'h0000, 1'b0);
        bv0 = bv_count; fin0 = fin_count; err0 = err_count;
        applyStimulus(8'h31, 0, 10, -1);
        ps2_data = 1'b0;
        waitCycles(HALF);
        ps2_clk = 1'b0;
        waitCycles(HALF);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        waitCycles(2 * HALF);
        checkOutput("stop_err_frame_err", err_count - err0, 1);
        checkOutput("stop_err_finished",  fin_count - fin0, 0);
        sendAndCheck("stop_after_31", 8'h31, 0, -1, 1, 1, 0, 16'h0031, 1'b0);

        // Timeout: start plus five data bits, then the clock stays high
        bv0 = bv_count; fin0 = fin_count; err0 = err_count;
        applyStimulus(8'h55, 0, 6, -1);
        waited = 0;
        while (err_count == err0 && waited < TIMEOUT + 200) begin
            waitCycles(1);
            waited++;
        end
        delay = err_cycle - last_fall;
        checkOutput("timeout_frame_err", err_count - err0, 1);
        checkOutput("timeout_no_finish", fin_count - fin0, 0);
        checkOutput("timeout_delay_in_window",
                    32'((delay >= TIMEOUT + 5) && (delay <= TIMEOUT + 25)), 1);
        sendAndCheck("timeout_72", 8'h72, 0, -1, 1, 1, 0, 16'h0072, 1'b0);

        // Short glitches on ps2_clk, first while idle and then mid-frame
        bv0 = bv_count; err0 = err_count;
        ps2_clk = 1'b0;
        waitCycles(3);
        ps2_clk = 1'b1;
        waitCycles(40);
        checkOutput("glitch_idle_bv",  bv_count - bv0, 0);
        checkOutput("glitch_idle_err", err_count - err0, 0);
        sendAndCheck("glitch_5A", 8'h5A, 0, 4, 1, 1, 0, 16'h005A, 1'b0);

        // Reset mid-frame after an E0 prefix
        sendAndCheck("rst_E0", 8'hE0, 0, -1, 1, 0, 0, 16'h0000, 1'b0);
        applyStimulus(8'h75, 0, 4, -1);
        rst_b = 1'b0;
        #3;
        checkOutput("rst_mid_scan_code", bus.scan_code, 16'h0000);
        checkOutput("rst_mid_raw_byte",  bus.raw_byte, 8'h00);
        checkOutput("rst_mid_break",     bus.break_code, 1'b0);
        waitCycles(5);
        rst_b = 1'b1;
        waitCycles(10);
        sendAndCheck("rst_after_75", 8'h75, 0, -1, 1, 1, 0, 16'h0075, 1'b0);

        checkOutput("finished_aligned_with_byte_valid", misalign, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
